// File: rtl/caravel_wb_window_bridge.sv
// Maps an 8 MB Caravel Wishbone window onto the 32-bit user-space bus through a 9-bit PAGE register.
// Define BRIDGE_TIMEOUT_EN to add a downstream ack timeout that sets a sticky STATUS flag.
module caravel_wb_window_bridge #(
  parameter logic [31:0] WINDOW_BASE    = 32'h3000_0000,
  parameter logic [31:0] CONFIG_BASE    = 32'h3080_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_data_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_data_o,
  output logic        userSpace_wb_cyc_o,
  output logic        userSpace_wb_stb_o,
  output logic        userSpace_wb_we_o,
  output logic [3:0]  userSpace_wb_sel_o,
  output logic [31:0] userSpace_wb_adr_o,
  output logic [31:0] userSpace_wb_data_o,
  input  logic        userSpace_wb_ack_i,
  input  logic [31:0] userSpace_wb_data_i
);

  typedef enum logic [1:0] {IDLE, FORWARD, RESPOND} state_t;

  state_t      state, state_next;
  logic [8:0]  page, page_next;
  logic        timeout_flag, timeout_flag_next;
  logic        ack_next;
  logic [31:0] rdata_next;
  logic        req_next;
  logic        we_next;
  logic [3:0]  sel_next;
  logic [31:0] adr_next;
  logic [31:0] wdata_next;
  logic        timeout_hit;

  logic request, window_hit, config_hit;
  assign request    = wbs_cyc_i & wbs_stb_i;
  assign window_hit = (wbs_adr_i[31:23] == WINDOW_BASE[31:23]);
  assign config_hit = (wbs_adr_i[31:3] == CONFIG_BASE[31:3]);

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic TIMEOUT_PRESENT = 1'b1;
  localparam int   CNT_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;

  // Counter is zero on FORWARD entry; firing at TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES cycles of cyc
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      to_cnt <= '0;
    else if (state != FORWARD)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == FORWARD) && (to_cnt == CNT_LAST);
`else
  localparam logic TIMEOUT_PRESENT = 1'b0;
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next        = state;
    page_next         = page;
    timeout_flag_next = timeout_flag;
    ack_next          = 1'b0;
    rdata_next        = 32'h0;
    req_next          = userSpace_wb_cyc_o;
    we_next           = userSpace_wb_we_o;
    sel_next          = userSpace_wb_sel_o;
    adr_next          = userSpace_wb_adr_o;
    wdata_next        = userSpace_wb_data_o;
    case (state)
      IDLE: begin
        if (request) begin
          if (window_hit) begin
            req_next   = 1'b1;
            we_next    = wbs_we_i;
            sel_next   = wbs_sel_i;
            adr_next   = {page, wbs_adr_i[22:0]};
            wdata_next = wbs_data_i;
            state_next = FORWARD;
          end else if (config_hit) begin
            ack_next   = 1'b1;
            state_next = RESPOND;
            if (!wbs_adr_i[2]) begin
              if (wbs_we_i) begin
                if (wbs_sel_i[0]) page_next[7:0] = wbs_data_i[7:0];
                if (wbs_sel_i[1]) page_next[8]   = wbs_data_i[8];
              end else begin
                rdata_next = {23'h0, page};
              end
            end else begin
              if (wbs_we_i) begin
                if (wbs_sel_i[0] && wbs_data_i[0]) timeout_flag_next = 1'b0;
              end else begin
                rdata_next = {30'h0, TIMEOUT_PRESENT, timeout_flag};
              end
            end
          end else begin
            ack_next   = 1'b1;
            rdata_next = 32'hFFFF_FFFF;
            state_next = RESPOND;
          end
        end
      end
      FORWARD: begin
        // Caravel abort beats everything; a downstream ack beats a coincident timeout
        if (!wbs_cyc_i) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (userSpace_wb_ack_i) begin
          req_next   = 1'b0;
          ack_next   = 1'b1;
          rdata_next = userSpace_wb_data_i;
          state_next = RESPOND;
        end else if (timeout_hit) begin
          req_next          = 1'b0;
          timeout_flag_next = 1'b1;
          ack_next          = 1'b1;
          rdata_next        = 32'hFFFF_FFFF;
          state_next        = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state               <= IDLE;
      page                <= 9'h0;
      timeout_flag        <= 1'b0;
      wbs_ack_o           <= 1'b0;
      wbs_data_o          <= 32'h0;
      userSpace_wb_cyc_o  <= 1'b0;
      userSpace_wb_stb_o  <= 1'b0;
      userSpace_wb_we_o   <= 1'b0;
      userSpace_wb_sel_o  <= 4'h0;
      userSpace_wb_adr_o  <= 32'h0;
      userSpace_wb_data_o <= 32'h0;
    end else begin
      state               <= state_next;
      page                <= page_next;
      timeout_flag        <= timeout_flag_next;
      wbs_ack_o           <= ack_next;
      wbs_data_o          <= rdata_next;
      userSpace_wb_cyc_o  <= req_next;
      userSpace_wb_stb_o  <= req_next;
      userSpace_wb_we_o   <= we_next;
      userSpace_wb_sel_o  <= sel_next;
      userSpace_wb_adr_o  <= adr_next;
      userSpace_wb_data_o <= wdata_next;
    end
  end

endmodule

// File: tb/tb_caravel_wb_window_bridge.sv
// Scoreboard bench for caravel_wb_window_bridge: a behavioural model predicts Caravel responses and
// user-space requests; separate monitors compare them as the DUT presents them.
module tb_caravel_wb_window_bridge;

  localparam int TO_CYCLES = 8;
  localparam logic [31:0] WIN_BASE = 32'h3000_0000;
  localparam logic [31:0] CFG_BASE = 32'h3080_0000;
`ifdef BRIDGE_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_data_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_data_o;
  logic        us_cyc, us_stb, us_we;
  logic [3:0]  us_sel;
  logic [31:0] us_adr, us_wdata;
  logic        us_ack;
  logic [31:0] us_rdata;

  caravel_wb_window_bridge #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .wb_clk_i           (wb_clk_i),
    .wb_rst_i           (wb_rst_i),
    .wbs_cyc_i          (wbs_cyc_i),
    .wbs_stb_i          (wbs_stb_i),
    .wbs_we_i           (wbs_we_i),
    .wbs_sel_i          (wbs_sel_i),
    .wbs_adr_i          (wbs_adr_i),
    .wbs_data_i         (wbs_data_i),
    .wbs_ack_o          (wbs_ack_o),
    .wbs_data_o         (wbs_data_o),
    .userSpace_wb_cyc_o (us_cyc),
    .userSpace_wb_stb_o (us_stb),
    .userSpace_wb_we_o  (us_we),
    .userSpace_wb_sel_o (us_sel),
    .userSpace_wb_adr_o (us_adr),
    .userSpace_wb_data_o(us_wdata),
    .userSpace_wb_ack_i (us_ack),
    .userSpace_wb_data_i(us_rdata)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] data;
    logic        chk;
  } resp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          exp_cycles;
  } ds_t;

  resp_t      resp_q[$];
  ds_t        ds_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] page_m;
  logic       flag_m;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model plus Caravel-side driver for one complete transaction
  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                               input logic [31:0] data, input int lat, input logic [31:0] rdata);
    resp_t r;
    ds_t   d;
    int    exp_lat;
    int    waited;
    r.chk   = 1'b0;
    r.data  = 32'hFFFF_FFFF;
    exp_lat = 1;
    if (adr[31:23] == WIN_BASE[31:23]) begin
      d.adr        = {page_m, adr[22:0]};
      d.we         = we;
      d.sel        = sel;
      d.wdata      = data;
      d.rdata      = rdata;
      d.lat        = lat;
      d.exp_cycles = (lat == 0) ? TO_CYCLES : lat;
      ds_q.push_back(d);
      exp_lat = d.exp_cycles + 1;
      if (lat == 0) begin
        r.chk  = 1'b1;
        r.data = 32'hFFFF_FFFF;
        flag_m = 1'b1;
      end else begin
        r.chk  = !we;
        r.data = rdata;
      end
    end else if (adr[31:3] == CFG_BASE[31:3]) begin
      if (!adr[2]) begin
        if (we) begin
          if (sel[0]) page_m[7:0] = data[7:0];
          if (sel[1]) page_m[8]   = data[8];
        end else begin
          r.chk  = 1'b1;
          r.data = {23'd0, page_m};
        end
      end else begin
        if (we) begin
          if (sel[0] && data[0]) flag_m = 1'b0;
        end else begin
          r.chk  = 1'b1;
          r.data = {30'd0, TO_EN, flag_m};
        end
      end
    end else begin
      r.chk  = 1'b1;
      r.data = 32'hFFFF_FFFF;
    end
    resp_q.push_back(r);

    @(negedge wb_clk_i);
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    wbs_we_i   = we;
    wbs_sel_i  = sel;
    wbs_adr_i  = adr;
    wbs_data_i = data;
    waited = 0;
    do begin
      @(negedge wb_clk_i);
      waited++;
    end while (!wbs_ack_o && waited < 60);
    checkOutput("ack_latency", waited, exp_lat);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    @(negedge wb_clk_i);
    checkOutput("data_idle", wbs_data_o, 32'h0);
  endtask

  task automatic applyAbort(input logic [31:0] adr, input int hold);
    ds_t d;
    d.adr = {page_m, adr[22:0]};
    d.we = 1'b0; d.sel = 4'hF; d.wdata = 32'h0; d.rdata = 32'h0;
    d.lat = 0; d.exp_cycles = -1;
    ds_q.push_back(d);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_data_i = 32'h0;
    repeat (hold) @(negedge wb_clk_i);
    checkOutput("abort_us_cyc_before", us_cyc, 1'b1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    checkOutput("abort_us_cyc_after", us_cyc, 1'b0);
    checkOutput("abort_us_stb_after", us_stb, 1'b0);
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic applyResetMidForward(input logic [31:0] adr);
    ds_t d;
    d.adr = {page_m, adr[22:0]};
    d.we = 1'b1; d.sel = 4'hF; d.wdata = 32'hA5A5_5A5A; d.rdata = 32'h0;
    d.lat = 0; d.exp_cycles = -1;
    ds_q.push_back(d);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_data_i = 32'hA5A5_5A5A;
    repeat (2) @(negedge wb_clk_i);
    checkOutput("pre_reset_us_cyc", us_cyc, 1'b1);
    #2 wb_rst_i = 1'b0;
    #1;
    checkOutput("rst_mid_us_cyc", us_cyc, 1'b0);
    checkOutput("rst_mid_us_stb", us_stb, 1'b0);
    checkOutput("rst_mid_us_ctl", {us_we, us_sel}, 5'h0);
    checkOutput("rst_mid_us_adr", us_adr, 32'h0);
    checkOutput("rst_mid_us_wdata", us_wdata, 32'h0);
    checkOutput("rst_mid_ack", wbs_ack_o, 1'b0);
    page_m = 9'h0;
    flag_m = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
  endtask

  // Caravel-side monitor: every ack pops one predicted response
  initial begin
    logic  prev_ack;
    resp_t r;
    prev_ack = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i && wbs_ack_o) begin
        checkOutput("ack_expected", resp_q.size() > 0, 1'b1);
        checkOutput("ack_single_pulse", prev_ack, 1'b0);
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          if (r.chk) checkOutput("resp_data", wbs_data_o, r.data);
        end
      end
      prev_ack = wbs_ack_o;
    end
  end

  // User-space slave model and request monitor
  initial begin
    ds_t  cur;
    logic active;
    int   cnt;
    active   = 1'b0;
    cnt      = 0;
    us_ack   = 1'b0;
    us_rdata = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      us_ack   = 1'b0;
      us_rdata = $urandom;
      if (us_cyc && us_stb) begin
        if (!active) begin
          checkOutput("us_cyc_expected", ds_q.size() > 0, 1'b1);
          if (ds_q.size() > 0) begin
            cur    = ds_q.pop_front();
            active = 1'b1;
            cnt    = 0;
            checkOutput("us_adr", us_adr, cur.adr);
          end
        end
        if (active) begin
          cnt++;
          checkOutput("us_we_sel_held", {us_we, us_sel}, {cur.we, cur.sel});
          checkOutput("us_wdata_held", us_wdata, cur.wdata);
          if (cur.lat != 0 && cnt == cur.lat) begin
            us_ack   = 1'b1;
            us_rdata = cur.rdata;
          end
        end
      end else if (active) begin
        active = 1'b0;
        if (cur.exp_cycles >= 0) checkOutput("us_cyc_cycles", cnt, cur.exp_cycles);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          kind;
    logic [31:0] a;
    wb_rst_i   = 1'b0;
    wbs_cyc_i  = 1'b0;
    wbs_stb_i  = 1'b0;
    wbs_we_i   = 1'b0;
    wbs_sel_i  = 4'h0;
    wbs_adr_i  = 32'h0;
    wbs_data_i = 32'h0;
    page_m     = 9'h0;
    flag_m     = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    checkOutput("reset_ack", wbs_ack_o, 1'b0);
    checkOutput("reset_data", wbs_data_o, 32'h0);
    checkOutput("reset_us_cyc_stb", {us_cyc, us_stb}, 2'b00);
    checkOutput("reset_us_ctl", {us_we, us_sel}, 5'h0);
    checkOutput("reset_us_adr", us_adr, 32'h0);
    checkOutput("reset_us_wdata", us_wdata, 32'h0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);

    applyStimulus(CFG_BASE,         1'b1, 4'hF, 32'h0000_01A3, 0, 32'h0);
    applyStimulus(CFG_BASE,         1'b0, 4'hF, 32'h0,         0, 32'h0);
    applyStimulus(CFG_BASE + 32'h4, 1'b0, 4'hF, 32'h0,         0, 32'h0);
    applyStimulus(CFG_BASE,         1'b1, 4'hF, 32'h0000_0060, 0, 32'h0);
    applyStimulus(32'h3000_0010,    1'b0, 4'hF, $urandom,      3, 32'hDEAD_BEEF);
    applyStimulus(CFG_BASE,         1'b1, 4'hF, 32'h0000_01FF, 0, 32'h0);
    applyStimulus(32'h307F_FFFC,    1'b1, 4'b0011, 32'h1234_5678, 4, $urandom);
    applyStimulus(32'h3100_0000,    1'b0, 4'hF, 32'h0,         0, 32'h0);
    applyStimulus(32'h3100_0000,    1'b1, 4'hF, 32'h0000_CAFE, 0, 32'h0);
    applyStimulus(CFG_BASE,         1'b1, 4'b0001, 32'h0000_0000, 0, 32'h0);
    applyStimulus(CFG_BASE,         1'b0, 4'hF, 32'h0,         0, 32'h0);
    applyStimulus(CFG_BASE,         1'b1, 4'b0010, 32'h0000_00AB, 0, 32'h0);
    applyStimulus(CFG_BASE,         1'b0, 4'hF, 32'h0,         0, 32'h0);
    applyStimulus(32'h3012_3458,    1'b0, 4'hF, 32'h0,         1, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: a = {WIN_BASE[31:23], 23'($urandom)};
        2: begin
          a    = CFG_BASE;
          a[2] = 1'($urandom_range(0, 1));
        end
        default: a = $urandom;
      endcase
      applyStimulus(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                    $urandom_range(1, 5), $urandom);
    end

`ifdef BRIDGE_TIMEOUT_EN
    applyStimulus(WIN_BASE + 32'h40, 1'b0, 4'hF, 32'h0, TO_CYCLES, 32'h1357_9BDF);
    applyStimulus(CFG_BASE + 32'h4,  1'b0, 4'hF, 32'h0, 0, 32'h0);
    applyStimulus(WIN_BASE + 32'h80, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    applyStimulus(CFG_BASE + 32'h4,  1'b0, 4'hF, 32'h0, 0, 32'h0);
    applyStimulus(CFG_BASE + 32'h4,  1'b1, 4'hF, 32'h1, 0, 32'h0);
    applyStimulus(CFG_BASE + 32'h4,  1'b0, 4'hF, 32'h0, 0, 32'h0);
`endif

    applyAbort(WIN_BASE + 32'h100, 3);
    applyStimulus(CFG_BASE, 1'b1, 4'hF, 32'h0000_0155, 0, 32'h0);
    applyResetMidForward(WIN_BASE + 32'h200);
    applyStimulus(CFG_BASE,         1'b0, 4'hF, 32'h0, 0, 32'h0);
    applyStimulus(CFG_BASE + 32'h4, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    applyStimulus(WIN_BASE + 32'h4, 1'b0, 4'hF, 32'h0, 2, 32'h2468_ACE0);

    repeat (5) @(negedge wb_clk_i);
    checkOutput("resp_queue_drained", resp_q.size(), 0);
    checkOutput("ds_queue_drained", ds_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
